// File: rtl/dsp48a1_mac_ctrl_pkg.sv
// rtl/dsp48a1_mac_ctrl_pkg.sv - shared types and OPMODE constants for the DSP48A1 MAC sequencer
package dsp48a1_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] OPMODE_NONE     = 8'h00;
  localparam logic [7:0] OPMODE_MUL_ZERO = 8'h01;
  localparam logic [7:0] OPMODE_MUL_ACC  = 8'h09;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/dsp48a1_mac_ctrl_if.sv
// rtl/dsp48a1_mac_ctrl_if.sv - job/operand handshake and slice control bundle (ABORT with DSP_MAC_CTRL_ABORT_EN)
interface dsp48a1_mac_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             CEA;
  logic             CEM;
  logic             CEP;
  logic [7:0]       OPMODE;
  logic             busy;
  logic             result_valid;
`ifdef DSP_MAC_CTRL_ABORT_EN
  logic             ABORT;
`endif

  modport master (
    output start, len, in_valid,
`ifdef DSP_MAC_CTRL_ABORT_EN
    output ABORT,
`endif
    input  in_ready, CEA, CEM, CEP, OPMODE, busy, result_valid
  );

  modport slave (
    input  start, len, in_valid,
`ifdef DSP_MAC_CTRL_ABORT_EN
    input  ABORT,
`endif
    output in_ready, CEA, CEM, CEP, OPMODE, busy, result_valid
  );

endinterface

// File: rtl/dsp48a1_mac_ctrl_tag_pipe.sv
// rtl/dsp48a1_mac_ctrl_tag_pipe.sv - issue-tag delay line; DEPTH=0 is a plain wire-through
module dsp_ctrl_tag_pipe
  import dsp48a1_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tag_out
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, clr};
    assign tag_out    = tag_in;
  end else begin : g_shift
    tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (clr) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= tag_in;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign tag_out = stage[DEPTH-1];
  end

endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// rtl/dsp48a1_mac_ctrl.sv - DSP48A1 MAC slice sequencer: CE/OPMODE generation per job; DSP_MAC_CTRL_ABORT_EN adds ABORT
module dsp48a1_mac_ctrl
  import dsp48a1_ctrl_pkg::*;
#(
  parameter int AREG  = 1,
  parameter int MREG  = 1,
  parameter int LEN_W = 8
) (
  input logic                CLK,
  input logic                RST,
  dsp48a1_mac_ctrl_if.slave  bus
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic             issue;
  logic             abort;
  tag_t             issue_tag, m_tag, p_tag;

`ifdef DSP_MAC_CTRL_ABORT_EN
  assign abort = bus.ABORT;
`else
  assign abort = 1'b0;
`endif

  assign bus.in_ready = (state == ISSUE) && (issued < len_q);
  assign issue        = bus.in_valid & bus.in_ready;

  always_comb begin
    issue_tag = '0;
    if (issue) begin
      issue_tag.valid = 1'b1;
      issue_tag.first = (issued == '0);
      issue_tag.last  = (issued == len_q - ONE);
    end
  end

  dsp_ctrl_tag_pipe #(.DEPTH(AREG)) u_m_tap (
    .clk     (CLK),
    .rst     (RST),
    .clr     (abort),
    .tag_in  (issue_tag),
    .tag_out (m_tag)
  );

  dsp_ctrl_tag_pipe #(.DEPTH(AREG + MREG)) u_p_tap (
    .clk     (CLK),
    .rst     (RST),
    .clr     (abort),
    .tag_in  (issue_tag),
    .tag_out (p_tag)
  );

  // Only the valid bit matters at the multiplier stage.
  logic unused_m_tag;
  assign unused_m_tag = ^{m_tag.first, m_tag.last};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      issued <= '0;
      len_q  <= '0;
    end else if (abort) begin
      issued <= '0;
    end else if (state == IDLE && bus.start) begin
      issued <= '0;
      len_q  <= bus.len;
    end else if (issue) begin
      issued <= issued + ONE;
    end
  end

  // The last tag reaching P ends the job even from ISSUE, which is the zero-latency case.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = (bus.len != '0) ? ISSUE : DONE;
      ISSUE: begin
        if (p_tag.valid && p_tag.last) state_nxt = DONE;
        else if (issued == len_q)      state_nxt = DRAIN;
      end
      DRAIN: if (p_tag.valid && p_tag.last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    bus.CEA          = issue;
    bus.CEM          = m_tag.valid;
    bus.CEP          = p_tag.valid;
    bus.busy         = (state != IDLE);
    bus.result_valid = (state == DONE) && (len_q != '0) && !abort;
    bus.OPMODE       = OPMODE_NONE;
    if (p_tag.valid) bus.OPMODE = p_tag.first ? OPMODE_MUL_ZERO : OPMODE_MUL_ACC;
  end

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// tb/tb_dsp48a1_mac_ctrl.sv - randomized bench for dsp48a1_mac_ctrl with two slice configurations
module tb_dsp48a1_mac_ctrl;

  localparam int MAXC = 2200;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] job_len;
  logic       in_valid;
  logic       abort;
  logic [7:0] a_in, b_in;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // index 0: AREG=MREG=1, index 1: AREG=MREG=0
  dsp48a1_mac_ctrl_if #(.LEN_W(8)) bus_a ();
  dsp48a1_mac_ctrl_if #(.LEN_W(8)) bus_b ();

  assign bus_a.start    = start;
  assign bus_a.len      = job_len;
  assign bus_a.in_valid = in_valid;
  assign bus_b.start    = start;
  assign bus_b.len      = job_len;
  assign bus_b.in_valid = in_valid;
`ifdef DSP_MAC_CTRL_ABORT_EN
  assign bus_a.ABORT    = abort;
  assign bus_b.ABORT    = abort;
`endif

  dsp48a1_mac_ctrl #(.AREG(1), .MREG(1), .LEN_W(8)) u_dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
  dsp48a1_mac_ctrl #(.AREG(0), .MREG(0), .LEN_W(8)) u_dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  // Behavioural DSP48A1 slices driven by each controller's enables
  logic [7:0]  ar, br;
  logic [15:0] mr;
  logic [47:0] p_a, p_b;

  always @(posedge clk) begin
    if (bus_a.CEA) begin ar <= a_in; br <= b_in; end
    if (bus_a.CEM) mr <= ar * br;
    if (bus_a.CEP) begin
      if (bus_a.OPMODE == 8'h01)      p_a <= {32'b0, mr};
      else if (bus_a.OPMODE == 8'h09) p_a <= p_a + {32'b0, mr};
    end
    if (bus_b.CEP) begin
      if (bus_b.OPMODE == 8'h01)      p_b <= 48'(a_in) * 48'(b_in);
      else if (bus_b.OPMODE == 8'h09) p_b <= p_b + 48'(a_in) * 48'(b_in);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit         vld  [MAXC];
  logic [7:0] av   [MAXC];
  logic [7:0] bv   [MAXC];
  logic       o_rdy[2][MAXC];
  logic       o_cea[2][MAXC];
  logic       o_cem[2][MAXC];
  logic       o_cep[2][MAXC];
  logic       o_rv [2][MAXC];
  logic       o_bsy[2][MAXC];
  logic [7:0] o_op [2][MAXC];
  logic [47:0] o_p [2][MAXC];

  task automatic sample(input int c);
    o_rdy[0][c] = bus_a.in_ready; o_rdy[1][c] = bus_b.in_ready;
    o_cea[0][c] = bus_a.CEA;      o_cea[1][c] = bus_b.CEA;
    o_cem[0][c] = bus_a.CEM;      o_cem[1][c] = bus_b.CEM;
    o_cep[0][c] = bus_a.CEP;      o_cep[1][c] = bus_b.CEP;
    o_rv[0][c]  = bus_a.result_valid; o_rv[1][c] = bus_b.result_valid;
    o_bsy[0][c] = bus_a.busy;     o_bsy[1][c] = bus_b.busy;
    o_op[0][c]  = bus_a.OPMODE;   o_op[1][c]  = bus_b.OPMODE;
    o_p[0][c]   = p_a;            o_p[1][c]   = p_b;
  endtask

  // Reference: pairs are accepted from cycle 1 until n are taken; each accepted pair reaches
  // the M stage la cycles and the P stage lp cycles later; the job ends one cycle after the last P.
  task automatic check_job(input int n, input int c_end);
    int eidx [MAXC];
    for (int k = 0; k < 2; k++) begin
      int la = (k == 0) ? 1 : 0;
      int lp = (k == 0) ? 2 : 0;
      int acc = 0, last = 0, done, ncea = 0, e;
      longint sum = 0;
      bit exp_rdy, exp_iss;
      logic [7:0] exp_op;
      for (int c = 0; c <= c_end; c++) begin
        exp_rdy = (c >= 1) && (acc < n);
        exp_iss = vld[c] && exp_rdy;
        eidx[c] = exp_iss ? acc : -1;
        if (exp_iss) begin
          sum += longint'(av[c]) * longint'(bv[c]);
          acc++;
          last = c;
        end
      end
      done = (n == 0) ? 1 : last + lp + 1;
      for (int c = 0; c <= c_end; c++) begin
        exp_rdy = (c >= 1) && (eidx[c] >= 0 || (c <= last && n > 0) || (n > 0 && acc < n));
        exp_rdy = (c >= 1) && (n > 0) && (c <= last);
        check_eq($sformatf("in_ready d%0d c%0d", k, c), o_rdy[k][c], exp_rdy);
        check_eq($sformatf("cea d%0d c%0d", k, c), o_cea[k][c], eidx[c] >= 0);
        if (o_cea[k][c] === 1'b1) ncea++;
        check_eq($sformatf("cem d%0d c%0d", k, c), o_cem[k][c], (c - la >= 0) && (eidx[c-la] >= 0));
        e = (c - lp >= 0) ? eidx[c-lp] : -1;
        check_eq($sformatf("cep d%0d c%0d", k, c), o_cep[k][c], e >= 0);
        exp_op = (e < 0) ? 8'h00 : (e == 0) ? 8'h01 : 8'h09;
        check_eq($sformatf("opmode d%0d c%0d", k, c), o_op[k][c], exp_op);
        check_eq($sformatf("result_valid d%0d c%0d", k, c), o_rv[k][c], (n > 0) && (c == done));
        check_eq($sformatf("busy d%0d c%0d", k, c), o_bsy[k][c], (c >= 1) && (c <= done));
        if (n > 0 && c == done) check_eq($sformatf("p_final d%0d", k), o_p[k][c], sum);
      end
      check_eq($sformatf("cea_count d%0d len%0d", k, n), ncea, n);
    end
  endtask

  // mode 0: in_valid held, 1: alternating 1,0,1,..., 2: random; st2 != 0 pulses start(len=7) mid-job
  task automatic run_job(input int n, input int mode, input int st2);
    int c = 0, acc = 0, last = 0;
    int budget = 8 * n + 24;
    bit stop = 0;
    while (!stop && c < MAXC && c < budget) begin
      @(posedge clk); #1;
      start   = (c == 0) || (st2 != 0 && c == st2);
      job_len = (c == 0) ? 8'(n) : 8'd7;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (c % 2 == 1);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (c == 0) in_valid = 1'b1;
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      vld[c] = in_valid;
      av[c]  = a_in;
      bv[c]  = b_in;
      @(negedge clk);
      sample(c);
      if (c >= 1 && acc < n && in_valid) begin acc++; last = c; end
      stop = (n == 0) ? (c >= 4) : (acc == n && c >= last + 5);
      c++;
    end
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check_job(n, c - 1);
  endtask

  task automatic reset_mid_drain();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      start    = (c == 0);
      job_len  = 8'd4;
      in_valid = 1'b1;
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("drain_busy", bus_a.busy, 1'b1);
    check_eq("drain_in_ready", bus_a.in_ready, 1'b0);
    check_eq("drain_cep", bus_a.CEP, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_busy_a", bus_a.busy, 1'b0);
    check_eq("rst_cep_a", bus_a.CEP, 1'b0);
    check_eq("rst_cem_a", bus_a.CEM, 1'b0);
    check_eq("rst_cea_a", bus_a.CEA, 1'b0);
    check_eq("rst_opmode_a", bus_a.OPMODE, 8'h00);
    check_eq("rst_rv_a", bus_a.result_valid, 1'b0);
    check_eq("rst_in_ready_a", bus_a.in_ready, 1'b0);
    check_eq("rst_busy_b", bus_b.busy, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef DSP_MAC_CTRL_ABORT_EN
  task automatic abort_mid_issue();
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      start    = (c == 0);
      job_len  = 8'd6;
      in_valid = (c < 8);
      abort    = (c == 3);
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
      @(negedge clk);
      if (c >= 3) check_eq($sformatf("abort_rv c%0d", c), bus_a.result_valid | bus_b.result_valid, 1'b0);
      if (c >= 4) begin
        check_eq($sformatf("abort_busy c%0d", c), bus_a.busy | bus_b.busy, 1'b0);
        check_eq($sformatf("abort_cep c%0d", c), bus_a.CEP | bus_b.CEP, 1'b0);
        check_eq($sformatf("abort_cem c%0d", c), bus_a.CEM | bus_b.CEM, 1'b0);
      end
    end
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    job_len  = 8'd0;
    in_valid = 1'b0;
    abort    = 1'b0;
    a_in     = 8'd0;
    b_in     = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", {bus_a.busy, bus_b.busy}, 2'b00);
    check_eq("reset_in_ready", {bus_a.in_ready, bus_b.in_ready}, 2'b00);
    check_eq("reset_ce", {bus_a.CEA, bus_a.CEM, bus_a.CEP, bus_b.CEM, bus_b.CEP}, 5'b0);
    check_eq("reset_opmode", {bus_a.OPMODE, bus_b.OPMODE}, 16'h0000);
    check_eq("reset_rv", {bus_a.result_valid, bus_b.result_valid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    run_job(4, 0, 0);
    run_job(3, 1, 0);
    run_job(0, 0, 0);
    run_job(5, 0, 3);
    run_job(2, 0, 0);
    reset_mid_drain();
    run_job(1, 0, 0);
    for (int i = 0; i < 6; i++) run_job($urandom_range(1, 20), 2, 0);
    run_job(255, 0, 0);
`ifdef DSP_MAC_CTRL_ABORT_EN
    abort_mid_issue();
    run_job(3, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
